keypad_scanner: RTL and testbench

//  Input-side counterpart of the multiplexed display scan: drives one active-low column of a
//  4x4 matrix keypad at a time, samples the active-low rows, debounces across full sweeps and

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_sweep.sv | 79 +++++++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS   = 4;
  localparam int unsigned NUM_COLS   = 4;
  localparam int unsigned KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StPressed,
    StDebRel
  } key_state_e;

  typedef enum logic [1:0] {
    SweepNone,
    SweepOne,
    SweepMulti
  } sweep_kind_e;

endpackage

// File: rtl/keypad_sweep.sv
// Column strobing, row synchronisation and per-sweep classification of the 16 key contacts.
module keypad_sweep
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_ROWS-1:0]   row_n_i,
  output logic [NUM_COLS-1:0]   col_n_o,
  output logic                  sweep_done_o,
  output sweep_kind_e           sweep_kind_o,
  output logic [KEY_CODE_W-1:0] sweep_code_o
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned NumKeys = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [DivW-1:0]     dwell_q, dwell_d;
  logic [1:0]          col_q, col_d;
  logic [NumKeys-1:0]  acc_q, acc_d;
  logic                dwell_end;
  logic [4:0]          num_low;

  assign dwell_end = (dwell_q == DivW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_q      <= '0;
      acc_q      <= '0;
    end else begin
      row_meta_q <= row_n_i;
      row_sync_q <= row_meta_q;
      dwell_q    <= dwell_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
    end
  end

  // acc_d folds in the sample taken this cycle, so the column-3 slot is classified on time.
  always_comb begin
    dwell_d = dwell_end ? '0 : dwell_q + DivW'(1);
    col_d   = dwell_end ? col_q + 2'd1 : col_q;
    acc_d   = acc_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (dwell_end && (col_q == 2'(c))) begin
          acc_d[r*NUM_COLS+c] = ~row_sync_q[r];
        end
      end
    end
  end

  always_comb begin
    num_low      = '0;
    sweep_code_o = '0;
    for (int i = 0; i < NumKeys; i++) begin
      if (acc_d[i]) begin
        num_low      = num_low + 5'd1;
        sweep_code_o = KEY_CODE_W'(i);
      end
    end
    if (num_low == 5'd0) begin
      sweep_kind_o = SweepNone;
    end else if (num_low == 5'd1) begin
      sweep_kind_o = SweepOne;
    end else begin
      sweep_kind_o = SweepMulti;
    end
  end

  assign sweep_done_o = dwell_end && (col_q == 2'd3);
  assign col_n_o      = ~(4'b0001 << col_q);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: debounces whole sweeps and emits one event per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 200000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [NUM_COLS-1:0]   col_n,
  input  logic [NUM_ROWS-1:0]   row_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int unsigned RunW = $clog2(DEBOUNCE_SCANS + 1);

  logic                  sweep_done;
  sweep_kind_e           sweep_kind;
  logic [KEY_CODE_W-1:0] sweep_code;

  key_state_e            state_q, state_d;
  logic [KEY_CODE_W-1:0] cand_q, cand_d;
  logic [RunW-1:0]       run_q, run_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;
  logic                  run_last;

  keypad_sweep #(
    .SCAN_DIV (SCAN_DIV)
  ) u_sweep (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_n_i      (row_n),
    .col_n_o      (col_n),
    .sweep_done_o (sweep_done),
    .sweep_kind_o (sweep_kind),
    .sweep_code_o (sweep_code)
  );

  // The current sweep would be the DEBOUNCE_SCANS-th of its run.
  assign run_last = (run_q == RunW'(DEBOUNCE_SCANS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cand_q      <= '0;
      run_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      run_q       <= run_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    run_d       = run_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (sweep_done) begin
      unique case (state_q)
        StIdle: begin
          if (sweep_kind == SweepOne) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d     = StPressed;
              key_code_d  = sweep_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              state_d = StDebPress;
              cand_d  = sweep_code;
              run_d   = RunW'(1);
            end
          end
        end
        StDebPress: begin
          if (sweep_kind == SweepOne) begin
            if (sweep_code == cand_q) begin
              if (run_last) begin
                state_d     = StPressed;
                key_code_d  = cand_q;
                key_valid_d = 1'b1;
                key_held_d  = 1'b1;
                run_d       = '0;
              end else begin
                run_d = run_q + RunW'(1);
              end
            end else begin
              cand_d = sweep_code;
              run_d  = RunW'(1);
            end
          end else begin
            state_d = StIdle;
            run_d   = '0;
          end
        end
        StPressed: begin
          if (sweep_kind == SweepNone) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = StIdle;
              key_held_d = 1'b0;
            end else begin
              state_d = StDebRel;
              run_d   = RunW'(1);
            end
          end
        end
        StDebRel: begin
          if (sweep_kind == SweepNone) begin
            if (run_last) begin
              state_d    = StIdle;
              key_held_d = 1'b0;
              run_d      = '0;
            end else begin
              run_d = run_q + RunW'(1);
            end
          end else begin
            // Key came back (or another appeared) before release settled: no new event.
            state_d = StPressed;
            run_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Sweep-aligned keypad stimulus checked against a sliding-window debounce model.
module tb_keypad_scanner;

  localparam int unsigned ScanDiv  = 4;
  localparam int unsigned DebScans = 2;
  localparam int unsigned SweepClk = 4 * ScanDiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          total = 0;
  int          bad = 0;

  // Model: recent sweep classifications plus accepted-key state.
  int          hist_kind[$];
  int          hist_code[$];
  bit          m_held;
  logic [3:0]  m_code;

  keypad_scanner #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_SCANS (DebScans)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist_kind.delete();
    hist_code.delete();
    m_held = 1'b0;
    m_code = 4'd0;
  endtask

  // Hold a key set for one full sweep and check every cycle of it.
  task automatic run_sweep(input logic [15:0] k);
    int         n;
    int         code;
    bit         ev;
    bit         all_one;
    bit         all_none;
    bit         old_held;
    logic [3:0] old_code;
    logic [3:0] one;
    logic [3:0] exp_col;

    keys = k;
    n = $countones(k);
    code = 0;
    for (int i = 0; i < 16; i++) if (k[i]) code = i;
    hist_kind.push_back(n == 0 ? 0 : (n == 1 ? 1 : 2));
    hist_code.push_back(code);
    if (hist_kind.size() > DebScans) begin
      void'(hist_kind.pop_front());
      void'(hist_code.pop_front());
    end

    old_held = m_held;
    old_code = m_code;
    ev = 1'b0;
    all_one = (hist_kind.size() == DebScans);
    all_none = all_one;
    foreach (hist_kind[j]) begin
      if (hist_kind[j] != 1 || hist_code[j] != hist_code[0]) all_one = 1'b0;
      if (hist_kind[j] != 0) all_none = 1'b0;
    end
    if (!m_held && all_one) begin
      ev = 1'b1;
      m_held = 1'b1;
      m_code = 4'(hist_code[0]);
    end else if (m_held && all_none) begin
      m_held = 1'b0;
    end

    one = 4'b0001;
    for (int i = 1; i <= SweepClk; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(one << ((i / ScanDiv) % 4));
      check("col_n", 16'(col_n), 16'(exp_col));
      check("key_valid", 16'(key_valid), (i == SweepClk) ? 16'(ev) : 16'd0);
      check("key_held", 16'(key_held), (i == SweepClk) ? 16'(m_held) : 16'(old_held));
      check("key_code", 16'(key_code), (i == SweepClk) ? 16'(m_code) : 16'(old_code));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] prev;
    logic [15:0] nk;
    int          sel;

    keys = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 16'(col_n), 16'h000E);
    check("rst_valid", 16'(key_valid), 16'd0);
    check("rst_held", 16'(key_held), 16'd0);
    check("rst_code", 16'(key_code), 16'd0);
    release_reset();

    // Idle scanning, about 100 clk.
    repeat (6) run_sweep(16'h0000);

    // Clean press of key 9 (row 2, col 1), then release.
    repeat (3) run_sweep(16'h0200);
    check("clean_code", 16'(key_code), 16'd9);
    repeat (2) run_sweep(16'h0000);
    check("clean_released", 16'(key_held), 16'd0);

    // Bounce: present, absent, present twice.
    run_sweep(16'h0200);
    run_sweep(16'h0000);
    repeat (2) run_sweep(16'h0200);
    repeat (2) run_sweep(16'h0000);

    // Keys 0 and 5 together, then release 5.
    repeat (4) run_sweep(16'h0021);
    repeat (2) run_sweep(16'h0001);
    repeat (2) run_sweep(16'h0000);

    // Roll-over from key 3 to key 12 without a clear sweep.
    repeat (2) run_sweep(16'h0008);
    run_sweep(16'h1008);
    repeat (2) run_sweep(16'h1000);
    repeat (2) run_sweep(16'h0000);
    check("roll_code", 16'(key_code), 16'd3);

    // Reset in the middle of a debounce run.
    run_sweep(16'h0200);
    keys = 16'h0200;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_col", 16'(col_n), 16'h000E);
    check("mid_rst_valid", 16'(key_valid), 16'd0);
    check("mid_rst_held", 16'(key_held), 16'd0);
    check("mid_rst_code", 16'(key_code), 16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
    repeat (3) run_sweep(16'h0200);
    repeat (2) run_sweep(16'h0000);

    // Random key sets, biased towards repeats so presses get accepted.
    prev = 16'h0000;
    for (int s = 0; s < 150; s++) begin
      sel = int'($urandom_range(0, 9));
      nk = 16'h0000;
      if (sel <= 2) begin
        nk = 16'h0000;
      end else if (sel <= 5 && prev != 16'h0000) begin
        nk = prev;
      end else if (sel <= 7 || sel <= 5) begin
        nk[$urandom_range(0, 15)] = 1'b1;
      end else begin
        nk[$urandom_range(0, 15)] = 1'b1;
        nk[$urandom_range(0, 15)] = 1'b1;
      end
      run_sweep(nk);
      prev = nk;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
